// File: rtl/data_mem_port.sv
// Load/store port between the ALU and a req/ack word-wide memory bus.
// Handles byte/half/word lanes, load extension, stalls and access timeout.
module data_mem_port #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        Clk,
    input  logic        Reset_L,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AddrErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic             access;
    logic             legal;
    logic             start;
    logic             timeout_hit;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       lo_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic [31:0]      read_q;
    logic [3:0]       be_sel;
    logic [31:0]      wdata_sel;
    logic [31:0]      shifted;
    logic [31:0]      load_val;

    always_comb begin
        legal = 1'b0;
        case (MemSize)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~Address[0];
            2'b10:   legal = (Address[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign access      = MemRead | MemWrite;
    assign start       = (state == IDLE) && access && legal;
    assign AddrErr     = (state == IDLE) && access && !legal;
    assign cnt_inc     = counter + CNT_W'(1);
    assign timeout_hit = (cnt_inc == TIMEOUT_C);
    // A rejected access must not expose a stale load result.
    assign ReadData    = AddrErr ? 32'h0 : read_q;

    always_ff @(posedge Clk) begin
        if (!Reset_L) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    Stall      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                Stall = 1'b1;
                if (mem_ack || timeout_hit) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        be_sel    = 4'b1111;
        wdata_sel = WriteData;
        case (MemSize)
            2'b00: begin
                be_sel    = 4'b0001 << Address[1:0];
                wdata_sel = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be_sel    = Address[1] ? 4'b1100 : 4'b0011;
                wdata_sel = {2{WriteData[15:0]}};
            end
            default: begin
                be_sel    = 4'b1111;
                wdata_sel = WriteData;
            end
        endcase
    end

    // Extraction uses the values latched at ACCESS entry, not the live inputs.
    always_comb begin
        shifted  = mem_rdata >> {lo_q, 3'b000};
        load_val = mem_rdata;
        case (size_q)
            2'b00:   load_val = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                         : {24'h0, shifted[7:0]};
            2'b01:   load_val = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                         : {16'h0, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            read_q    <= '0;
            BusErr    <= 1'b0;
            counter   <= '0;
            lo_q      <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= Address[31:2];
                        mem_be    <= be_sel;
                        mem_wdata <= wdata_sel;
                        lo_q      <= Address[1:0];
                        size_q    <= MemSize;
                        signed_q  <= MemSigned;
                        counter   <= '0;
                    end else if (AddrErr) begin
                        read_q <= '0;
                    end
                end
                ACCESS: begin
                    counter <= cnt_inc;
                    // An ack on the timeout cycle still completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) read_q <= load_val;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        read_q  <= '0;
                        BusErr  <= 1'b1;
                    end
                end
                DONE: begin
                    BusErr  <= 1'b0;
                    counter <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_port.sv
// Table-driven bench for data_mem_port: directed load/store vectors plus
// hand-written timeout, late-ack and mid-access reset sequences.
module tb_data_mem_port;

    logic        Clk = 1'b0;
    logic        Reset_L;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        AddrErr;
    logic        BusErr;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clk = ~Clk;

    data_mem_port #(.TIMEOUT(15), .CNT_W(8)) dut (
        .Clk(Clk), .Reset_L(Reset_L), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemSigned(MemSigned), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .AddrErr(AddrErr), .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          ack_dly;
        logic        aerr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          stalls;
        logic [31:0] rdout;
        logic        buserr;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic clearInputs();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemSize   = 2'b00;
        MemSigned = 1'b0;
        Address   = '0;
        WriteData = '0;
    endtask

    task automatic applyStimulus(input vec_t v, input string nm);
        int          stalls = 0;
        int          reqc   = 0;
        int          req_seen = 0;
        logic        got = 1'b0;
        logic        done = 1'b0;
        logic        a_err = 1'b0;
        logic        f_we = 1'b0;
        logic [3:0]  f_be = '0;
        logic [31:0] f_wdata = '0;
        logic [29:0] f_addr = '0;
        logic [31:0] d_rd = '0;
        logic        d_berr = 1'b0;
        @(posedge Clk); #1;
        MemRead   = v.rd;
        MemWrite  = v.wr;
        MemSize   = v.size;
        MemSigned = v.sgn;
        Address   = v.addr;
        WriteData = v.wd;
        mem_rdata = v.rdata;
        mem_ack   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge Clk);
            mem_ack = 1'b0;
            if (c == 0) a_err = AddrErr;
            if (mem_req) begin
                reqc++;
                if (!got) begin
                    got     = 1'b1;
                    f_we    = mem_we;
                    f_be    = mem_be;
                    f_wdata = mem_wdata;
                    f_addr  = mem_addr;
                end
                if (reqc == v.ack_dly) mem_ack = 1'b1;
            end
            if (Stall) stalls++;
            else begin
                done   = 1'b1;
                d_rd   = ReadData;
                d_berr = BusErr;
            end
        end
        checkOutput({nm, "_done"}, {31'h0, done}, 32'h1);
        checkOutput({nm, "_aerr"}, {31'h0, a_err}, {31'h0, v.aerr});
        if (v.aerr) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge Clk);
                if (mem_req) req_seen++;
            end
            checkOutput({nm, "_stall"}, stalls, 0);
            checkOutput({nm, "_rdata"}, d_rd, 32'h0);
            checkOutput({nm, "_noreq"}, req_seen, 0);
            clearInputs();
        end else begin
            clearInputs();
            checkOutput({nm, "_stalls"}, stalls, v.stalls);
            checkOutput({nm, "_reqcyc"}, reqc, v.stalls - 1);
            checkOutput({nm, "_be"}, {28'h0, f_be}, {28'h0, v.be});
            checkOutput({nm, "_wdata"}, f_wdata, v.wdata);
            checkOutput({nm, "_addr"}, {2'b00, f_addr}, v.addr >> 2);
            checkOutput({nm, "_we"}, {31'h0, f_we}, {31'h0, v.we});
            checkOutput({nm, "_rdout"}, d_rd, v.rdout);
            checkOutput({nm, "_buserr"}, {31'h0, d_berr}, {31'h0, v.buserr});
        end
    endtask

    initial begin
        clearInputs();
        mem_rdata = '0;
        mem_ack   = 1'b0;
        Reset_L   = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset_L = 1'b1;
        @(negedge Clk);
        checkOutput("rst_req", {31'h0, mem_req}, 32'h0);
        checkOutput("rst_stall", {31'h0, Stall}, 32'h0);
        checkOutput("rst_rdata", ReadData, 32'h0);
        checkOutput("rst_be", {28'h0, mem_be}, 32'h0);

        //              rd    wr    size   sgn   addr         wd            rdata        dly aerr  we    be      wdata         st rdout         berr
        vecs.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        1, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 2, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h000000AB, 32'h80112233, 1, 1'b0, 1'b0, 4'h8, 32'hABABABAB, 2, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h000000AB, 32'h80112233, 1, 1'b0, 1'b0, 4'h8, 32'hABABABAB, 2, 32'h00000080, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        32'h80017FFF, 1, 1'b0, 1'b0, 4'hC, 32'h0,        2, 32'hFFFF8001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 32'h0,        1, 1'b0, 1'b1, 4'hC, 32'h12341234, 2, 32'hFFFF8001, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0,        32'h80017FFF, 2, 1'b0, 1'b0, 4'h3, 32'h0,        3, 32'h00007FFF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0,        32'h00007F00, 1, 1'b0, 1'b0, 4'h2, 32'h0,        2, 32'h0000007F, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 32'h102, 32'h1122335A, 32'h0,        1, 1'b0, 1'b1, 4'h4, 32'h5A5A5A5A, 2, 32'h0000007F, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEBABE, 32'hFFFFFFFF, 1, 1'b0, 1'b1, 4'hF, 32'hCAFEBABE, 2, 32'h0000007F, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        32'h0,        1, 1'b1, 1'b0, 4'h0, 32'h0,        0, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b1, 32'h103, 32'h0,        32'h0,        1, 1'b1, 1'b0, 4'h0, 32'h0,        0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'b11, 1'b0, 32'h100, 32'h0,        32'h0,        1, 1'b1, 1'b0, 4'h0, 32'h0,        0, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0,        32'h12345678, 3, 1'b0, 1'b0, 4'hF, 32'h0,        4, 32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h204, 32'h0,        32'h87654321, 0, 1'b0, 1'b0, 4'hF, 32'h0,       16, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h208, 32'h0,        32'hCAFEF00D,15, 1'b0, 1'b0, 4'hF, 32'h0,       16, 32'hCAFEF00D, 1'b0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
            // After a timed-out access, a late ack must not disturb anything.
            if (vecs[i].buserr) begin
                @(negedge Clk);
                mem_ack = 1'b1;
                @(negedge Clk);
                mem_ack = 1'b0;
                checkOutput("late_req", {31'h0, mem_req}, 32'h0);
                checkOutput("late_rdata", ReadData, 32'h0);
                checkOutput("late_buserr", {31'h0, BusErr}, 32'h0);
                checkOutput("late_stall", {31'h0, Stall}, 32'h0);
            end
        end

        // Reset in the middle of an access abandons it.
        @(posedge Clk); #1;
        MemRead   = 1'b1;
        MemSize   = 2'b10;
        Address   = 32'h300;
        WriteData = 32'h55AA55AA;
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("rmid_req", {31'h0, mem_req}, 32'h1);
        Reset_L = 1'b0;
        clearInputs();
        @(negedge Clk);
        checkOutput("rmid_req0", {31'h0, mem_req}, 32'h0);
        checkOutput("rmid_stall", {31'h0, Stall}, 32'h0);
        checkOutput("rmid_rdata", ReadData, 32'h0);
        checkOutput("rmid_be", {28'h0, mem_be}, 32'h0);
        checkOutput("rmid_addr", {2'b00, mem_addr}, 32'h0);
        checkOutput("rmid_wdata", mem_wdata, 32'h0);
        Reset_L   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        mem_ack   = 1'b1;
        @(negedge Clk);
        mem_ack = 1'b0;
        checkOutput("rack_req", {31'h0, mem_req}, 32'h0);
        checkOutput("rack_rdata", ReadData, 32'h0);
        checkOutput("rack_stall", {31'h0, Stall}, 32'h0);
        checkOutput("rack_buserr", {31'h0, BusErr}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
